// File: rtl/cond_unit_pipe.sv
// rtl/cond_unit_pipe.sv - execute-stage ARM condition unit with NZCV register, gating and squash counter
module cond_unit_pipe #(
  parameter int OUT_REG   = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 valid,
  input  logic [3:0]           cond,
  input  logic [3:0]           alu_flags,
  input  logic [1:0]           flag_w,
  input  logic                 pcs,
  input  logic                 reg_w,
  input  logic                 mem_w,
  input  logic                 clr_cnt,
  output logic                 cond_ex,
  output logic                 pc_src,
  output logic                 reg_write,
  output logic                 mem_write,
  output logic                 illegal_cond,
  output logic [3:0]           flags,
  output logic [CNT_WIDTH-1:0] squash_count
);

  logic [3:0] flag_q;
  logic       n, z, c, v;
  logic       active;
  logic       pc_src_g, reg_write_g, mem_write_g;

  assign {n, z, c, v} = flag_q;
  assign flags        = flag_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c & !z;
      4'b1001: cond_ex = !c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = !z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // flush and stall both kill the slot; everything downstream keys off this
  assign active       = valid & en & !flush;
  assign illegal_cond = active & (cond == 4'b1111);
  assign pc_src_g     = pcs   & cond_ex & active;
  assign reg_write_g  = reg_w & cond_ex & active;
  assign mem_write_g  = mem_w & cond_ex & active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= 4'b0000;
    end else if (active & cond_ex) begin
      if (flag_w[1]) flag_q[3:2] <= alu_flags[3:2];
      if (flag_w[0]) flag_q[1:0] <= alu_flags[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      squash_count <= '0;
    end else if (clr_cnt) begin
      squash_count <= '0;
    end else if (active & !cond_ex & (cond != 4'b1111) & (squash_count != {CNT_WIDTH{1'b1}})) begin
      squash_count <= squash_count + CNT_WIDTH'(1);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      // gated terms already fold in flush, so an enabled edge loads 0 on flush
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pc_src    <= 1'b0;
          reg_write <= 1'b0;
          mem_write <= 1'b0;
        end else if (en) begin
          pc_src    <= pc_src_g;
          reg_write <= reg_write_g;
          mem_write <= mem_write_g;
        end
      end
    end else begin : g_out_comb
      assign pc_src    = pc_src_g;
      assign reg_write = reg_write_g;
      assign mem_write = mem_write_g;
    end
  endgenerate

endmodule
